regfile_read_bypass: RTL and testbench
======================================

REGFILE_READ_BYPASS -- requirements
Module: regfile_read_bypass

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk sampled on rising edge; reset synchronous, active-high.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the sole clock.
REQ-003 The port reset SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-004 The port readAddressAReg SHALL be an input, 5 bits wide, carrying the registered read address for port A.
REQ-005 The port readAddressBReg SHALL be an input, 5 bits wide, carrying the registered read address for port B.
REQ-006 The ports ramDataA and ramDataB SHALL be inputs, 32 bits wide, carrying register-array read data for A/B, valid in the same cycle as the address.
REQ-007 The ports writeEnableAReg and writeEnableBReg SHALL be inputs, 1 bit wide, carrying the write-port commit enables.
REQ-008 The ports writeAddressAReg and writeAddressBReg SHALL be inputs, 5 bits wide, carrying the write-port addresses.
REQ-009 The ports writeDataA and writeDataB SHALL be inputs, 32 bits wide, carrying the write-port data committed this cycle.
REQ-010 The port stall SHALL be an input, 1 bit wide; while high, it holds the outputs for their current addresses.
REQ-011 The ports readDataA and readDataB SHALL be outputs, 32 bits wide, carrying registered read results.
REQ-012 The port readValid SHALL be an output, 1 bit wide, asserted when readDataA/B hold a captured result.
REQ-013 The port bypassCount SHALL be an output, 16 bits wide, carrying a saturating count of bypass hits.

Function
REQ-014 ramDataA/B SHALL be treated as array contents before the writes committed in the same cycle (read-during-write returns old data).
REQ-015 Per read port, a non-stalled cycle SHALL select, in priority order: zero if the address is 0; writeDataB if writeEnableAReg/BReg... specifically writeEnableBReg=1 and writeAddressBReg equals the read address; writeDataA on an A match; otherwise ramData.
REQ-016 Address 0 SHALL always read as 32'h0, even if written.
REQ-017 When stall=0, the selected value SHALL be registered into readData at the next rising edge (latency 1 cycle), and the read address SHALL be captured into an internal held address.
REQ-018 When stall=1, readAddressAReg/BReg and ramData SHALL be ignored, and readData SHALL hold, except for snooping: a write committed that cycle to the held address (non-zero) SHALL update readData at the next edge, with B priority over A.
REQ-019 Snooping SHALL continue for every cycle of a multi-cycle stall, so readData is never stale on stall release.
REQ-020 readValid SHALL rise at the edge ending the first non-stalled post-reset cycle and then stay 1 until reset.
REQ-021 bypassCount SHALL increment by the number of ports (0, 1 or 2) whose selection in REQ-015 came from a write port during a non-stalled cycle.
REQ-022 bypassCount SHALL saturate at 16'hFFFF, and an increment of 2 from 16'hFFFE SHALL give 16'hFFFF.
REQ-023 Snoop updates during a stall SHALL NOT increment bypassCount.
REQ-024 Ports A and B SHALL be fully independent: both may bypass from the same write port in the same cycle.

Reset
REQ-025 When reset=1 at a rising edge, readDataA, readDataB, the held addresses, readValid and bypassCount SHALL all become 0.
REQ-026 reset SHALL take precedence over stall and over all writes in that cycle.
REQ-027 Reset asserted mid-stall SHALL discard the held state, and the first post-reset read SHALL behave as in REQ-017.

Verification
REQ-028 Plain read: readAddressAReg=3, ramDataA=32'h1111, no writes, stall=0 -> next cycle readDataA=32'h1111, readValid=1, bypassCount=0.
REQ-029 Dual bypass: readAddressAReg=readAddressBReg=7, both writes to 7 (A=32'hAAAA, B=32'hBBBB), ramData=32'h0 -> readDataA=readDataB=32'hBBBB, bypassCount=2.
REQ-030 Zero register: readAddressAReg=0, writeEnableBReg=1, writeAddressBReg=0, writeDataB=32'hFFFF, ramDataA=32'h5 -> readDataA=32'h0, bypassCount unchanged.
REQ-031 Stall snoop: capture addr 9 (=32'h1), then stall 3 cycles with writeA to 9 = 32'h22 in stall cycle 2 -> readDataA=32'h22 after that edge, held through release, bypassCount unchanged.
REQ-032 Saturation: bypassCount=16'hFFFE, dual bypass cycle -> 16'hFFFF; a further bypass cycle -> stays 16'hFFFF.
REQ-033 Reset mid-stall: readDataA=32'h22, stall=1, reset=1 for one edge -> all outputs 0, readValid=0; next unstalled read captured normally.

Source files
------------

// File: rtl/regfile_read_bypass.sv
// Registered two-port register-file read stage with write-port bypass,
// stall-time snooping of the held addresses, and a saturating bypass-hit counter.
module regfile_read_bypass (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  readAddressAReg,
    input  logic [4:0]  readAddressBReg,
    input  logic [31:0] ramDataA,
    input  logic [31:0] ramDataB,
    input  logic        writeEnableAReg,
    input  logic        writeEnableBReg,
    input  logic [4:0]  writeAddressAReg,
    input  logic [4:0]  writeAddressBReg,
    input  logic [31:0] writeDataA,
    input  logic [31:0] writeDataB,
    input  logic        stall,
    output logic [31:0] readDataA,
    output logic [31:0] readDataB,
    output logic        readValid,
    output logic [15:0] bypassCount
);

    logic [4:0]  held_addr_a;
    logic [4:0]  held_addr_b;
    logic [4:0]  sel_addr_a;
    logic [4:0]  sel_addr_b;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [32:0] pick_a;
    logic [32:0] pick_b;
    logic [1:0]  hit_inc;
    logic [16:0] cnt_sum;

    // Returns {hit, data}: write port B wins over A, address 0 is hard-wired zero.
    function automatic logic [32:0] pick(
        input logic [4:0]  addr,
        input logic [31:0] fallback,
        input logic        we_a,
        input logic [4:0]  wa_a,
        input logic [31:0] wd_a,
        input logic        we_b,
        input logic [4:0]  wa_b,
        input logic [31:0] wd_b
    );
        logic [32:0] r;
        if (addr == 5'd0)
            r = {1'b0, 32'h0};
        else if (we_b && (wa_b == addr))
            r = {1'b1, wd_b};
        else if (we_a && (wa_a == addr))
            r = {1'b1, wd_a};
        else
            r = {1'b0, fallback};
        return r;
    endfunction

    // While stalled the held address is snooped and the current output is the fallback.
    always_comb begin
        sel_addr_a = stall ? held_addr_a : readAddressAReg;
        sel_addr_b = stall ? held_addr_b : readAddressBReg;
        base_a     = stall ? readDataA : ramDataA;
        base_b     = stall ? readDataB : ramDataB;
        pick_a = pick(sel_addr_a, base_a, writeEnableAReg, writeAddressAReg, writeDataA,
                      writeEnableBReg, writeAddressBReg, writeDataB);
        pick_b = pick(sel_addr_b, base_b, writeEnableAReg, writeAddressAReg, writeDataA,
                      writeEnableBReg, writeAddressBReg, writeDataB);
        hit_inc = 2'd0;
        if (!stall)
            hit_inc = {1'b0, pick_a[32]} + {1'b0, pick_b[32]};
        cnt_sum = {1'b0, bypassCount} + {15'd0, hit_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readDataA   <= 32'h0;
            readDataB   <= 32'h0;
            held_addr_a <= 5'd0;
            held_addr_b <= 5'd0;
            readValid   <= 1'b0;
            bypassCount <= 16'h0;
        end else begin
            readDataA <= pick_a[31:0];
            readDataB <= pick_b[31:0];
            if (!stall) begin
                held_addr_a <= readAddressAReg;
                held_addr_b <= readAddressBReg;
                readValid   <= 1'b1;
            end
            bypassCount <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_regfile_read_bypass.sv
// Self-checking bench: a reference model pushes expected outputs per cycle and
// they are popped and compared one cycle after the stimulus edge.
module tb_regfile_read_bypass;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readAddressAReg, readAddressBReg;
    logic [31:0] ramDataA, ramDataB;
    logic        writeEnableAReg, writeEnableBReg;
    logic [4:0]  writeAddressAReg, writeAddressBReg;
    logic [31:0] writeDataA, writeDataB;
    logic        stall;
    logic [31:0] readDataA, readDataB;
    logic        readValid;
    logic [15:0] bypassCount;

    regfile_read_bypass dut (
        .clk(clk), .reset(reset),
        .readAddressAReg(readAddressAReg), .readAddressBReg(readAddressBReg),
        .ramDataA(ramDataA), .ramDataB(ramDataB),
        .writeEnableAReg(writeEnableAReg), .writeEnableBReg(writeEnableBReg),
        .writeAddressAReg(writeAddressAReg), .writeAddressBReg(writeAddressBReg),
        .writeDataA(writeDataA), .writeDataB(writeDataB),
        .stall(stall),
        .readDataA(readDataA), .readDataB(readDataB),
        .readValid(readValid), .bypassCount(bypassCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [80:0] exp_q[$];

    // Reference model state
    logic [31:0] m_a, m_b;
    logic [4:0]  m_ha, m_hb;
    logic        m_v;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_port(input logic [4:0] addr, input logic [31:0] other,
                              inout logic [31:0] data, output int hit);
        hit = 0;
        if (addr == 0) data = 32'h0;
        else if (writeEnableBReg && writeAddressBReg == addr) begin data = writeDataB; hit = 1; end
        else if (writeEnableAReg && writeAddressAReg == addr) begin data = writeDataA; hit = 1; end
        else data = other;
    endtask

    task automatic model_step();
        int ha, hb, total;
        logic [31:0] na, nb;
        if (reset) begin
            m_a = 0; m_b = 0; m_ha = 0; m_hb = 0; m_v = 0; m_cnt = 0;
        end else if (!stall) begin
            na = m_a; nb = m_b;
            model_port(readAddressAReg, ramDataA, na, ha);
            model_port(readAddressBReg, ramDataB, nb, hb);
            m_a = na; m_b = nb;
            m_ha = readAddressAReg; m_hb = readAddressBReg; m_v = 1'b1;
            total = int'(m_cnt) + ha + hb;
            m_cnt = (total > 65535) ? 16'hFFFF : 16'(total);
        end else begin
            na = m_a; nb = m_b;
            model_port(m_ha, m_a, na, ha);
            model_port(m_hb, m_b, nb, hb);
            m_a = na; m_b = nb;
        end
        exp_q.push_back({m_a, m_b, m_v, m_cnt});
    endtask

    // One cycle: drive inputs, model, clock edge, pop and compare.
    task automatic cycle(input logic rst, input logic st,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] da, input logic [31:0] db,
                         input logic wea, input logic [4:0] aa, input logic [31:0] wa,
                         input logic web, input logic [4:0] ab, input logic [31:0] wb);
        logic [80:0] e;
        reset = rst; stall = st;
        readAddressAReg = ra; readAddressBReg = rb; ramDataA = da; ramDataB = db;
        writeEnableAReg = wea; writeAddressAReg = aa; writeDataA = wa;
        writeEnableBReg = web; writeAddressBReg = ab; writeDataB = wb;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("readDataA", readDataA, e[80:49]);
            check("readDataB", readDataB, e[48:17]);
            check("readValid", {31'd0, readValid}, {31'd0, e[16]});
            check("bypassCount", {16'd0, bypassCount}, {16'd0, e[15:0]});
        end
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, st, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    logic [15:0] cnt_before;

    initial begin
        m_a = 0; m_b = 0; m_ha = 0; m_hb = 0; m_v = 0; m_cnt = 0;
        #2;
        // Reset state
        cycle(1'b1, 1'b0, 5'd3, 5'd4, 32'h5, 32'h6, 1'b1, 5'd3, 32'h9, 1'b1, 5'd4, 32'h9);
        check("rst_valid", {31'd0, readValid}, 32'd0);
        check("rst_dataA", readDataA, 32'h0);

        // Plain read
        cycle(1'b0, 1'b0, 5'd3, 5'd5, 32'h1111, 32'h2222, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("plain_dataA", readDataA, 32'h1111);
        check("plain_valid", {31'd0, readValid}, 32'd1);
        check("plain_cnt", {16'd0, bypassCount}, 32'd0);

        // Dual bypass, B priority
        cycle(1'b0, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        check("dual_dataA", readDataA, 32'hBBBB);
        check("dual_dataB", readDataB, 32'hBBBB);
        check("dual_cnt", {16'd0, bypassCount}, 32'd2);

        // Single A bypass on port B only
        cycle(1'b0, 1'b0, 5'd2, 5'd8, 32'h33, 32'h44, 1'b1, 5'd8, 32'hA8, 1'b0, 5'd8, 32'hB8);
        check("abyp_dataB", readDataB, 32'hA8);
        check("abyp_cnt", {16'd0, bypassCount}, 32'd3);

        // Zero register
        cnt_before = bypassCount;
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 32'h5, 32'h5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
        check("zero_dataA", readDataA, 32'h0);
        check("zero_cnt", {16'd0, bypassCount}, {16'd0, cnt_before});

        // Stall snoop
        cycle(1'b0, 1'b0, 5'd9, 5'd10, 32'h1, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("snoop_cap", readDataA, 32'h1);
        cnt_before = bypassCount;
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 32'hDEAD, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("stall_hold", readDataA, 32'h1);
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 32'hDEAD, 32'hDEAD, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
        check("snoop_upd", readDataA, 32'h22);
        cycle(1'b0, 1'b1, 5'd9, 5'd10, 32'hDEAD, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("snoop_hold", readDataA, 32'h22);
        check("snoop_cnt", {16'd0, bypassCount}, {16'd0, cnt_before});
        cycle(1'b0, 1'b0, 5'd9, 5'd10, 32'h22, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("release", readDataA, 32'h22);

        // Reset mid-stall
        idle(1'b1);
        cycle(1'b1, 1'b1, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 32'h88);
        check("rst_stall_data", readDataA, 32'h0);
        check("rst_stall_valid", {31'd0, readValid}, 32'd0);
        cycle(1'b0, 1'b0, 5'd12, 5'd13, 32'hC0C0, 32'hD0D0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("post_rst_read", readDataA, 32'hC0C0);
        check("post_rst_valid", {31'd0, readValid}, 32'd1);

        // Random traffic on a narrow address range to provoke hits and snoops
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        // Saturation: reset, drive the count to FFFE with dual bypasses
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32767; i++) begin
            cycle(1'b0, 1'b0, 5'd4, 5'd4, 32'h0, 32'h0, 1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'h0);
        end
        check("sat_pre", {16'd0, bypassCount}, 32'h0000FFFE);
        cycle(1'b0, 1'b0, 5'd4, 5'd4, 32'h0, 32'h0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
        check("sat_reach", {16'd0, bypassCount}, 32'h0000FFFF);
        cycle(1'b0, 1'b0, 5'd4, 5'd5, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 32'h0);
        check("sat_hold", {16'd0, bypassCount}, 32'h0000FFFF);

        if (exp_q.size() != 0) check("queue_left", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
